// File: rtl/pinmux_pkg.sv
// Shared pad-attribute types, pad-type masks and sequencer state encoding.
package pinmux_pkg;

  typedef enum logic [1:0] {
    PadBidirStd,
    PadBidirOd,
    PadInputStd,
    PadAnalog
  } pad_type_e;

  typedef struct packed {
    logic       invert;
    logic       pull_en;
    logic       pull_sel;
    logic       keeper;
    logic       od_en;
    logic       slew;
    logic [1:0] drive;
  } pad_attr_t;

  typedef enum logic [2:0] {
    SeqIdle,
    SeqIsoPre,
    SeqUpdate,
    SeqIsoPost,
    SeqDone
  } seq_state_e;

  // Bits a given pad type can actually hold; everything else reads back as 0.
  function automatic logic [7:0] warl_mask(pad_type_e t);
    case (t)
      PadBidirStd: return 8'hFF;
      PadBidirOd:  return 8'hFB;
      PadInputStd: return 8'hF0;
      default:     return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/pinmux_pad_attr_seq.sv
// Isolate / update / release sequencer for a single pad-attribute change.
module pinmux_pad_attr_seq
  import pinmux_pkg::*;
#(
  parameter int NumPads      = 8,
  parameter int SettleCycles = 4,
  localparam int AW = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [AW-1:0]      addr_i,
  input  pad_attr_t          leg_i,
  output logic [NumPads-1:0] iso_o,
  output logic               upd_o,
  output logic [AW-1:0]      upd_addr_o,
  output pad_attr_t          upd_leg_o,
  output logic               done_o,
  output logic               busy_o
);

  // A settle time of zero still needs one isolated cycle around the update.
  localparam int S  = (SettleCycles < 1) ? 1 : SettleCycles;
  localparam int CW = $clog2(S + 1);

  seq_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  pad_attr_t          leg_q, leg_d;
  logic [NumPads-1:0] iso_q, iso_d;

  // Next-state, settle counter and isolation vector.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    leg_d   = leg_q;
    iso_d   = iso_q;
    case (state_q)
      SeqIdle: begin
        if (start_i) begin
          state_d = SeqIsoPre;
          cnt_d   = '0;
          addr_d  = addr_i;
          leg_d   = leg_i;
          for (int i = 0; i < NumPads; i++) iso_d[i] = (AW'(i) == addr_i);
        end
      end
      SeqIsoPre, SeqIsoPost: begin
        if (cnt_q == CW'(S - 1)) begin
          state_d = (state_q == SeqIsoPre) ? SeqUpdate : SeqDone;
          cnt_d   = '0;
        end else if (cnt_q != CW'(S)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SeqUpdate: begin
        state_d = SeqIsoPost;
        cnt_d   = '0;
      end
      SeqDone: begin
        state_d = SeqIdle;
        iso_d   = '0;
      end
      default: begin
        state_d = SeqIdle;
        iso_d   = '0;
      end
    endcase
  end

  // Sequencer registers; reset abandons any pending change and releases isolation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SeqIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      leg_q   <= '0;
      iso_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      leg_q   <= leg_d;
      iso_q   <= iso_d;
    end
  end

  assign iso_o      = iso_q;
  assign upd_o      = (state_q == SeqUpdate);
  assign upd_addr_o = addr_q;
  assign upd_leg_o  = leg_q;
  assign done_o     = (state_q == SeqDone);
  assign busy_o     = (state_q != SeqIdle);

endmodule

// File: rtl/pinmux_pad_attr_ctrl.sv
// Runtime pad-attribute register bank with WARL legalisation and glitch-free apply.
module pinmux_pad_attr_ctrl
  import pinmux_pkg::*;
#(
  parameter int        NumPads      = 8,
  parameter pad_type_e PadType      = PadBidirStd,
  parameter int        SettleCycles = 4,
  parameter pad_attr_t ResetAttr    = '0,
  localparam int AW = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [7:0]           wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [7:0]           rdata_o,
  output logic                 err_o,
  output logic [NumPads*8-1:0] attr_o,
  output logic [NumPads-1:0]   iso_o,
  output logic                 busy_o
);

  localparam logic [7:0]  Mask     = warl_mask(PadType);
  localparam pad_attr_t   ResetLeg = ResetAttr & Mask;
  localparam logic [AW:0] NpVal    = (AW + 1)'(NumPads);

  pad_attr_t  attr_q [NumPads];
  pad_attr_t  attr_d [NumPads];
  logic       rvalid_q, rvalid_d;
  logic       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;

  logic       gnt, in_range, start;
  pad_attr_t  cur, leg;
  logic       seq_upd, seq_done, seq_busy;
  logic [AW-1:0] seq_addr;
  pad_attr_t  seq_leg;

  // Handshake, read path and decision whether a write needs the sequencer.
  always_comb begin
    gnt      = req_i && !seq_busy;
    in_range = ({1'b0, addr_i} < NpVal);
    leg      = wdata_i & Mask;
    cur      = '0;
    for (int i = 0; i < NumPads; i++) begin
      if (AW'(i) == addr_i) cur = attr_q[i];
    end
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    start    = 1'b0;
    if (seq_done) begin
      rvalid_d = 1'b1;
      rdata_d  = seq_leg;
    end
    if (gnt) begin
      if (!in_range) begin
        rvalid_d = 1'b1;
        err_d    = 1'b1;
        rdata_d  = '0;
      end else if (!we_i) begin
        rvalid_d = 1'b1;
        rdata_d  = cur;
      end else if (leg == cur) begin
        rvalid_d = 1'b1;
        rdata_d  = leg;
      end else begin
        start = 1'b1;
      end
    end
  end

  // Attribute array only changes on the sequencer's update strobe.
  always_comb begin
    attr_d = attr_q;
    for (int i = 0; i < NumPads; i++) begin
      if (seq_upd && (AW'(i) == seq_addr)) attr_d[i] = seq_leg;
    end
  end

  // Attribute and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumPads; i++) attr_q[i] <= ResetLeg;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      attr_q   <= attr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Flatten the array for the pad ring.
  always_comb begin
    attr_o = '0;
    for (int i = 0; i < NumPads; i++) attr_o[i*8 +: 8] = attr_q[i];
  end

  pinmux_pad_attr_seq #(
    .NumPads      (NumPads),
    .SettleCycles (SettleCycles)
  ) u_seq (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start),
    .addr_i     (addr_i),
    .leg_i      (leg),
    .iso_o      (iso_o),
    .upd_o      (seq_upd),
    .upd_addr_o (seq_addr),
    .upd_leg_o  (seq_leg),
    .done_o     (seq_done),
    .busy_o     (seq_busy)
  );

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign busy_o   = seq_busy;

endmodule

// File: tb/tb_pinmux_pad_attr_ctrl.sv
// Randomised bench for pinmux_pad_attr_ctrl against a transaction-level pad model.
module tb_pinmux_pad_attr_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Index 0: 8 pads, BidirStd, settle 4.  Index 1: 6 pads, BidirOd, settle 0.
  logic       req [2];
  logic       we [2];
  logic [2:0] addr [2];
  logic [7:0] wdata [2];
  logic       gnt [2];
  logic       rvalid [2];
  logic       err [2];
  logic       busy [2];
  logic [7:0] rdata [2];
  logic [63:0] attr_a, attr_c;
  logic [47:0] attr_b;
  logic [7:0]  iso_a, iso_c;
  logic [5:0]  iso_b;
  logic [63:0] attr_flat [2];
  logic [7:0]  iso_v [2];
  logic        gnt_c, rvalid_c, err_c, busy_c;
  logic [7:0]  rdata_c;

  assign attr_flat[0] = attr_a;
  assign attr_flat[1] = {16'h0, attr_b};
  assign iso_v[0]     = iso_a;
  assign iso_v[1]     = {2'b00, iso_b};

  pinmux_pad_attr_ctrl #(
    .NumPads(8), .PadType(pinmux_pkg::PadBidirStd), .SettleCycles(4),
    .ResetAttr(pinmux_pkg::pad_attr_t'(8'h00))
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .attr_o(attr_a), .iso_o(iso_a), .busy_o(busy[0])
  );

  pinmux_pad_attr_ctrl #(
    .NumPads(6), .PadType(pinmux_pkg::PadBidirOd), .SettleCycles(0),
    .ResetAttr(pinmux_pkg::pad_attr_t'(8'h0F))
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .attr_o(attr_b), .iso_o(iso_b), .busy_o(busy[1])
  );

  pinmux_pad_attr_ctrl #(
    .NumPads(8), .PadType(pinmux_pkg::PadInputStd), .SettleCycles(4),
    .ResetAttr(pinmux_pkg::pad_attr_t'(8'hFF))
  ) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(1'b0), .we_i(1'b0), .addr_i(3'd0),
    .wdata_i(8'h00), .gnt_o(gnt_c), .rvalid_o(rvalid_c), .rdata_o(rdata_c),
    .err_o(err_c), .attr_o(attr_c), .iso_o(iso_c), .busy_o(busy_c)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] mdl [2][8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int num_pads(input int w);
    return (w != 0) ? 6 : 8;
  endfunction

  function automatic int settle(input int w);
    return (w != 0) ? 1 : 4;
  endfunction

  function automatic logic [63:0] model_flat(input int w);
    logic [63:0] v;
    v = '0;
    for (int p = 0; p < num_pads(w); p++) v[p*8 +: 8] = mdl[w][p];
    return v;
  endfunction

  task automatic reset_model();
    for (int p = 0; p < 8; p++) begin
      mdl[0][p] = 8'h00;
      mdl[1][p] = (p < 6) ? 8'h0B : 8'h00;
    end
  endtask

  // One complete transaction: request, grant, then per-cycle pad checks until completion.
  task automatic access(input int w, input bit wr, input logic [2:0] ad, input logic [7:0] wd);
    int np, s, lat;
    logic [7:0] leg, old, exp_rd;
    logic [63:0] exp_flat, exp_iso;
    bit chg, er, got, done;
    np  = num_pads(w);
    s   = settle(w);
    leg = wd & ((w != 0) ? 8'hFB : 8'hFF);
    er  = (int'(ad) >= np);
    old = er ? 8'h00 : mdl[w][ad];
    chg = 1'b0;
    if (er) exp_rd = 8'h00;
    else if (!wr) exp_rd = old;
    else begin
      exp_rd = leg;
      chg    = (leg != old);
    end
    lat = chg ? 2*s + 3 : 1;
    @(posedge clk); #1;
    req[w] = 1'b1; we[w] = wr; addr[w] = ad; wdata[w] = wd;
    got = 1'b0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      got = gnt[w];
    end
    check("gnt", 64'(got), 64'd1);
    @(posedge clk); #1;
    req[w] = 1'b0; we[w] = 1'b0;
    if (!got) return;
    done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      exp_iso  = (chg && k <= 2*s + 2) ? (64'd1 << ad) : 64'd0;
      exp_flat = model_flat(w);
      if (chg && k >= s + 2) exp_flat[int'(ad)*8 +: 8] = leg;
      check("iso", 64'(iso_v[w]), exp_iso);
      check("attr", attr_flat[w], exp_flat);
      check("busy", 64'(busy[w]), 64'(chg && k <= 2*s + 2));
      if (rvalid[w]) begin
        done = 1'b1;
        check("latency", 64'(k), 64'(lat));
        check("rdata", 64'(rdata[w]), 64'(exp_rd));
        check("err", 64'(err[w]), 64'(er));
      end
    end
    if (!done) check("rvalid_timeout", 64'd0, 64'd1);
    if (chg) mdl[w][ad] = leg;
  endtask

  // A read held during a write sequence is granted on the first idle cycle.
  task automatic hold_test();
    logic [7:0] nv;
    nv = mdl[0][5] ^ 8'h3C;
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 3'd5; wdata[0] = nv;
    @(negedge clk);
    check("hold_first_gnt", 64'(gnt[0]), 64'd1);
    @(posedge clk); #1;
    we[0] = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k < 11) check("hold_gnt_low", 64'(gnt[0]), 64'd0);
      else begin
        check("hold_wr_rvalid", 64'(rvalid[0]), 64'd1);
        check("hold_wr_rdata", 64'(rdata[0]), 64'(nv));
        check("hold_gnt_idle", 64'(gnt[0]), 64'd1);
      end
    end
    mdl[0][5] = nv;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("hold_rd_rvalid", 64'(rvalid[0]), 64'd1);
    check("hold_rd_rdata", 64'(rdata[0]), 64'(nv));
  endtask

  // Asynchronous reset while the target pad is in its post-update isolation window.
  task automatic reset_mid();
    logic [7:0] nv;
    nv = mdl[0][2] ^ 8'h81;
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 3'd2; wdata[0] = nv;
    @(negedge clk);
    check("rst_gnt", 64'(gnt[0]), 64'd1);
    @(posedge clk); #1;
    req[0] = 1'b0; we[0] = 1'b0;
    for (int k = 1; k <= 7; k++) @(negedge clk);
    check("rst_pre_iso", 64'(iso_a), 64'h04);
    check("rst_pre_attr", 64'(attr_a[23:16]), 64'(nv));
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    check("rst_iso", 64'(iso_a), 64'd0);
    check("rst_busy", 64'(busy[0]), 64'd0);
    check("rst_attr_a", attr_a, model_flat(0));
    check("rst_attr_b", attr_flat[1], model_flat(1));
    check("rst_rvalid", 64'(rvalid[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b1, 3'd2, 8'h77);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, np;
    bit wr;
    logic [2:0] ad;
    logic [7:0] wd;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 3'd0; wdata[i] = 8'h00;
    end
    reset_model();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_attr_a", attr_a, model_flat(0));
    check("reset_attr_b", attr_flat[1], model_flat(1));
    check("reset_attr_c", attr_c, {8{8'hF0}});
    check("reset_iso", {iso_c, iso_v[1], iso_v[0]}, 64'd0);
    check("reset_busy", {busy_c, busy[1], busy[0]}, 64'd0);
    check("reset_rvalid_err", {rvalid[0], rvalid[1], err[0], err[1], rvalid_c, err_c}, 64'd0);
    check("reset_rdata", {rdata[0], rdata[1], rdata_c}, 64'd0);
    rst_n = 1'b1;

    access(0, 1'b1, 3'd3, 8'hA5);
    access(1, 1'b1, 3'd0, 8'hFF);
    access(1, 1'b0, 3'd0, 8'h00);
    access(1, 1'b1, 3'd0, 8'hFB);
    access(1, 1'b1, 3'd7, 8'h55);
    access(1, 1'b0, 3'd6, 8'h00);
    access(1, 1'b1, 3'd2, 8'h3C);
    access(0, 1'b0, 3'd3, 8'h00);
    hold_test();
    reset_mid();

    for (int n = 0; n < 60; n++) begin
      w  = int'($urandom_range(0, 1));
      np = num_pads(w);
      wr = 1'($urandom_range(0, 1));
      ad = 3'($urandom_range(0, 7));
      wd = 8'($urandom);
      if ($urandom_range(0, 3) == 0 && int'(ad) < np) wd = mdl[w][ad];
      access(w, wr, ad, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
